// File: rtl/lava_pkg.sv
// Shared types and fixed-point constants for the metaball rasteriser.
// Q17.15 positions/field values, RGB444 colours, raster FSM states.
package lava_pkg;

  localparam int          FRAC_W = 15;
  localparam logic [31:0] FX_ONE = 32'h0000_8000;

  typedef logic [11:0] rgb444_t;
  typedef logic [31:0] fx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STROBE,
    ST_GUARD,
    ST_WAIT,
    ST_WRITE,
    ST_SWAP
  } raster_state_t;

endpackage

// File: rtl/metaball_raster_field_quant.sv
// Saturating sum of all engine fields, quantised to a palette colour.
// Highest passing threshold wins; below the first threshold is black.
module field_quant
  import lava_pkg::*;
#(
  parameter int N_BALLS = 2,
  parameter int LEVELS  = 4
) (
  input  logic [N_BALLS*32-1:0] ball_val_i,
  input  logic [LEVELS*32-1:0]  thresh_i,
  input  logic [LEVELS*12-1:0]  palette_i,
  output rgb444_t               colour_o
);

  logic [35:0] acc;
  fx_t         sum;

  // Wide accumulate, then clamp anything past 32 bits
  always_comb begin
    acc = '0;
    for (int i = 0; i < N_BALLS; i++) begin
      acc = acc + {4'b0000, ball_val_i[32*i +: 32]};
    end
    sum = (|acc[35:32]) ? 32'hFFFF_FFFF : acc[31:0];
  end

  // Later entries override earlier ones: highest index that passes
  always_comb begin
    colour_o = '0;
    for (int i = 0; i < LEVELS; i++) begin
      if (sum >= thresh_i[32*i +: 32]) begin
        colour_o = palette_i[12*i +: 12];
      end
    end
  end

endmodule

// File: rtl/metaball_raster.sv
// On-demand column-major raster of summed metaball fields into
// top/bottom RGB444 half-buffers, with a swap pulse per frame.
module metaball_raster
  import lava_pkg::*;
#(
  parameter int N_BALLS = 2,
  parameter int COLS    = 32,
  parameter int ROWS    = 64,
  parameter int LEVELS  = 4,
  parameter int ADDR_W  = $clog2(COLS*ROWS/2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_go,
  input  logic [N_BALLS-1:0]    ball_vld,
  input  logic [N_BALLS*32-1:0] ball_val,
  input  logic [LEVELS*32-1:0]  thresh,
  input  logic [LEVELS*12-1:0]  palette,
  output logic                  px_stb,
  output logic [31:0]           p_x,
  output logic [31:0]           p_y,
  output logic                  w_en_top,
  output logic                  w_en_btm,
  output logic [ADDR_W-1:0]     w_addr,
  output logic [11:0]           din,
  output logic                  swap_en,
  output logic                  busy
);

  localparam int HALF = ROWS / 2;
  localparam int XW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  raster_state_t state_q, state_d;
  logic          pend_q, pend_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  rgb444_t       col_q, col_d;

  rgb444_t       quant_col;
  logic          last_px;
  logic          top;
  logic          wr;
  logic [YW-1:0] y_half;

  field_quant #(
    .N_BALLS (N_BALLS),
    .LEVELS  (LEVELS)
  ) u_quant (
    .ball_val_i (ball_val),
    .thresh_i   (thresh),
    .palette_i  (palette),
    .colour_o   (quant_col)
  );

  assign last_px = (x_q == XW'(COLS - 1)) && (y_q == YW'(ROWS - 1));

  // Raster sequencing: start, strobe engines, wait, write, advance
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | (frame_go && (state_q != ST_IDLE));
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_go || pend_q) begin
          pend_d  = 1'b0;
          x_d     = '0;
          y_d     = '0;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: state_d = ST_GUARD;
      ST_GUARD:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (&ball_vld) begin
          col_d   = quant_col;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (last_px) begin
          state_d = ST_SWAP;
        end else begin
          state_d = ST_STROBE;
          if (y_q == YW'(ROWS - 1)) begin
            y_d = '0;
            x_d = x_q + 1'b1;
          end else begin
            y_d = y_q + 1'b1;
          end
        end
      end
      ST_SWAP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, pending request, pixel counters and captured colour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
    end
  end

  assign wr     = (state_q == ST_WRITE);
  assign top    = (y_q < YW'(HALF));
  assign y_half = top ? y_q : (y_q - YW'(HALF));

  assign px_stb   = (state_q == ST_STROBE);
  assign swap_en  = (state_q == ST_SWAP);
  assign busy     = (state_q == ST_STROBE) || (state_q == ST_GUARD) ||
                    (state_q == ST_WAIT)   || (state_q == ST_WRITE);
  assign p_x      = fx_t'(x_q) << FRAC_W;
  assign p_y      = fx_t'(y_q) << FRAC_W;
  assign w_en_top = wr & top;
  assign w_en_btm = wr & ~top;
  assign w_addr   = wr ? (ADDR_W'(x_q) * ADDR_W'(HALF) + ADDR_W'(y_half))
                       : '0;
  assign din      = wr ? col_q : '0;

endmodule

// File: tb/tb_metaball_raster.sv
// Scoreboard bench for metaball_raster: engine model, pixel model,
// pending-frame collapse, stall hold and mid-frame reset.
module tb_metaball_raster;

  localparam int NB   = 2;
  localparam int COLS = 32;
  localparam int ROWS = 64;
  localparam int LV   = 4;
  localparam int AW   = 10;

  logic            clk;
  logic            rst_n;
  logic            frame_go;
  logic [NB-1:0]   ball_vld;
  logic [NB*32-1:0] ball_val;
  logic [LV*32-1:0] thresh;
  logic [LV*12-1:0] palette;
  logic            px_stb;
  logic [31:0]     p_x;
  logic [31:0]     p_y;
  logic            w_en_top;
  logic            w_en_btm;
  logic [AW-1:0]   w_addr;
  logic [11:0]     din;
  logic            swap_en;
  logic            busy;

  metaball_raster #(
    .N_BALLS (NB),
    .COLS    (COLS),
    .ROWS    (ROWS),
    .LEVELS  (LV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame_go (frame_go),
    .ball_vld (ball_vld),
    .ball_val (ball_val),
    .thresh   (thresh),
    .palette  (palette),
    .px_stb   (px_stb),
    .p_x      (p_x),
    .p_y      (p_y),
    .w_en_top (w_en_top),
    .w_en_btm (w_en_btm),
    .w_addr   (w_addr),
    .din      (din),
    .swap_en  (swap_en),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        top;
    logic [9:0]  addr;
    logic [11:0] col;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] th [LV];
  logic [11:0] pal[LV];

  int n_cmp = 0;
  int n_bad = 0;

  int idx = 0;
  int cyc = 0;
  int swaps = 0;
  int wr_top = 0;
  int wr_btm = 0;
  int last_swap = 0;
  int cnt0 = 0;
  int cnt1 = 0;
  int stall_bad = 0;
  int stall_seen = 0;
  bit prev_wr = 0;
  bit want_gap = 0;
  bit gap_armed = 0;
  bit in_stall = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_col(input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] s;
    logic [11:0] c;
    s = {32'd0, a} + {32'd0, b};
    if (s > 64'h0000_0000_FFFF_FFFF) s = 64'h0000_0000_FFFF_FFFF;
    c = 12'h000;
    for (int i = 0; i < LV; i++) begin
      if (s >= {32'd0, th[i]}) c = pal[i];
    end
    return c;
  endfunction

  // Field patterns cycle every 256 pixels across the frame
  task automatic pick_vals(input int n, output logic [31:0] a,
                           output logic [31:0] b);
    case ((n / 256) % 5)
      0: begin a = 32'h0000_4000; b = 32'h0000_4000; end
      1: begin a = 32'h0000_C000; b = 32'h0000_8000; end
      2: begin a = 32'h0000_2000; b = 32'h0000_2000; end
      3: begin a = 32'hFFFF_0000; b = 32'hFFFF_0000; end
      default: begin a = 32'h0001_0000; b = 32'h0001_0000; end
    endcase
  endtask

  // Engine model plus scoreboard push/pop, sampled on the falling edge
  initial begin
    logic [31:0] va;
    logic [31:0] vb;
    exp_t        e;
    int          x;
    int          y;
    bit          wr;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sbq.delete();
        idx = 0; wr_top = 0; wr_btm = 0; prev_wr = 0;
        cnt0 = 0; cnt1 = 0; in_stall = 0;
        ball_vld = '1;
      end else begin
        wr = w_en_top | w_en_btm;
        if (wr) begin
          if (sbq.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e = sbq.pop_front();
            check("w_en_top", w_en_top, e.top);
            check("w_en_btm", w_en_btm, !e.top);
            check("w_addr", w_addr, e.addr);
            check("din", din, e.col);
          end
          if (w_en_top) wr_top++;
          else wr_btm++;
        end
        if (swap_en) begin
          check("swap_vs_write", wr, 0);
          check("swap_after_last", prev_wr, 1);
          check("top_writes", wr_top, 1024);
          check("btm_writes", wr_btm, 1024);
          check("sb_drained", sbq.size(), 0);
          swaps++;
          last_swap = cyc;
          wr_top = 0; wr_btm = 0; idx = 0;
          if (want_gap) begin
            gap_armed = 1;
            want_gap = 0;
          end
        end
        prev_wr = wr;
        if (in_stall) begin
          if (ball_vld[1]) begin
            check("stall_hold", stall_bad, 0);
            check("stall_seen", stall_seen > 40, 1);
            in_stall = 0;
          end else if (ball_vld[0]) begin
            stall_seen++;
            if (wr || p_x != 32'h0001_8000 || p_y != 32'h0005_0000)
              stall_bad++;
          end
        end
        if (px_stb) begin
          if (gap_armed) begin
            check("restart_gap", cyc - last_swap, 2);
            gap_armed = 0;
          end
          x = idx / ROWS;
          y = idx % ROWS;
          check("p_x", p_x, x << 15);
          check("p_y", p_y, y << 15);
          pick_vals(idx, va, vb);
          ball_val = {vb, va};
          ball_vld = '0;
          cnt0 = 2;
          cnt1 = (idx == 3 * ROWS + 10) ? 52 : 2;
          if (idx == 3 * ROWS + 10) begin
            in_stall = 1; stall_bad = 0; stall_seen = 0;
          end
          e.top  = (y < ROWS / 2);
          e.addr = 10'(x * (ROWS / 2) + (e.top ? y : y - ROWS / 2));
          e.col  = ref_col(va, vb);
          sbq.push_back(e);
          idx++;
        end else begin
          if (cnt0 > 0) begin
            cnt0--;
            if (cnt0 == 0) ball_vld[0] = 1'b1;
          end
          if (cnt1 > 0) begin
            cnt1--;
            if (cnt1 == 0) ball_vld[1] = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_idx(input int n);
    int t;
    t = 0;
    while (idx < n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("reach_pixel", idx >= n, 1);
  endtask

  task automatic wait_swaps(input int n);
    int t;
    t = 0;
    while (swaps < n && t < 40000) begin
      @(negedge clk);
      t++;
    end
    check("frames_done", swaps, n);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_px_stb"}, px_stb, 0);
    check({tag, "_p_x"}, p_x, 0);
    check({tag, "_p_y"}, p_y, 0);
    check({tag, "_w_en_top"}, w_en_top, 0);
    check({tag, "_w_en_btm"}, w_en_btm, 0);
    check({tag, "_w_addr"}, w_addr, 0);
    check({tag, "_din"}, din, 0);
    check({tag, "_swap_en"}, swap_en, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic pulse_go();
    @(negedge clk);
    frame_go = 1'b1;
    @(negedge clk);
    frame_go = 1'b0;
  endtask

  initial begin
    th  = '{32'h0000_8000, 32'h0001_0000, 32'h0001_8000, 32'h0002_0000};
    pal = '{12'hA01, 12'hB02, 12'hC03, 12'hD04};
    for (int i = 0; i < LV; i++) begin
      thresh[32*i +: 32]  = th[i];
      palette[12*i +: 12] = pal[i];
    end
    rst_n    = 1'b1;
    frame_go = 1'b0;
    ball_vld = '1;
    ball_val = '0;
    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // Frame A with two mid-frame requests collapsing into frame B
    @(negedge clk);
    frame_go = 1'b1;
    @(negedge clk);
    frame_go = 1'b0;
    check("start_busy", busy, 1);
    check("start_stb", px_stb, 1);
    want_gap = 1;
    wait_idx(100);
    pulse_go();
    wait_idx(400);
    pulse_go();
    wait_swaps(1);
    wait_swaps(2);
    repeat (40) @(negedge clk);
    check("no_third_frame", swaps, 2);
    check("no_extra_stb", idx, 0);
    check("after_busy", busy, 0);

    // Frame C abandoned by reset around pixel 500
    pulse_go();
    wait_idx(500);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    repeat (30) @(negedge clk);
    check("no_swap_on_reset", swaps, 2);
    rst_n = 1'b1;

    // Frame D restarts cleanly from (0,0)
    @(negedge clk);
    frame_go = 1'b1;
    @(negedge clk);
    frame_go = 1'b0;
    check("restart_stb", px_stb, 1);
    check("restart_px", p_x, 0);
    check("restart_py", p_y, 0);
    wait_swaps(3);
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
